// File: rtl/demux14_buffered_if.sv
// Handshake bundle for the buffered 1-to-4 demultiplexer: one routed input
// stream with a destination select, four output channels and the full flags.
interface demux14_buffered_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] I;
  logic [1:0]       S;
  logic             I_VALID;
  logic             I_READY;

  logic [WIDTH-1:0] OA;
  logic [WIDTH-1:0] OB;
  logic [WIDTH-1:0] OC;
  logic [WIDTH-1:0] OD;
  logic             OA_VALID;
  logic             OB_VALID;
  logic             OC_VALID;
  logic             OD_VALID;
  logic             OA_READY;
  logic             OB_READY;
  logic             OC_READY;
  logic             OD_READY;

  logic [3:0]       FULL;

  // Producer and consumers of the routed stream.
  modport master (
    output I, S, I_VALID,
    input  I_READY,
    input  OA, OB, OC, OD,
    input  OA_VALID, OB_VALID, OC_VALID, OD_VALID,
    output OA_READY, OB_READY, OC_READY, OD_READY,
    input  FULL
  );

  // The demultiplexer itself.
  modport slave (
    input  I, S, I_VALID,
    output I_READY,
    output OA, OB, OC, OD,
    output OA_VALID, OB_VALID, OC_VALID, OD_VALID,
    input  OA_READY, OB_READY, OC_READY, OD_READY,
    output FULL
  );
endinterface

// File: rtl/demux14_buffered.sv
// Buffered 1-to-4 demultiplexer: each word goes to the channel named by S and
// waits in that channel's own DEPTH-entry FIFO, so one stalled consumer only
// blocks words addressed to itself.
module demux14_buffered #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input logic              CLK,
  input logic              RST,
  demux14_buffered_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [WIDTH-1:0] mem_r [4][DEPTH];
  logic [PTR_W-1:0] wr_ptr_r [4];
  logic [PTR_W-1:0] rd_ptr_r [4];
  logic [CNT_W-1:0] count_r [4];

  logic [3:0]       cons_ready_s;
  logic [3:0]       valid_s;
  logic [3:0]       full_s;
  logic [3:0]       push_s;
  logic [3:0]       pop_s;
  logic             in_ready_s;
  logic [WIDTH-1:0] head_s [4];

  // Gather the per-channel consumer readies into one vector.
  always_comb begin
    cons_ready_s = {bus.OD_READY, bus.OC_READY, bus.OB_READY, bus.OA_READY};
  end

  // Acceptance looks only at the selected channel's current count; a pop in
  // the same cycle does not open room for the incoming word.
  always_comb begin
    in_ready_s = (count_r[bus.S] < DEPTH_C);
  end

  // Per-channel status, push/pop strobes and zero-gated head word.
  always_comb begin
    valid_s = 4'b0000;
    full_s  = 4'b0000;
    push_s  = 4'b0000;
    pop_s   = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      valid_s[c] = (count_r[c] != '0);
      full_s[c]  = (count_r[c] == DEPTH_C);
      push_s[c]  = bus.I_VALID && in_ready_s && (bus.S == 2'(c));
      pop_s[c]   = valid_s[c] && cons_ready_s[c];
      if (valid_s[c]) begin
        head_s[c] = mem_r[c][rd_ptr_r[c]];
      end else begin
        head_s[c] = '0;
      end
    end
  end

  // Drive the interface outputs.
  always_comb begin
    bus.I_READY  = in_ready_s;
    bus.OA       = head_s[0];
    bus.OB       = head_s[1];
    bus.OC       = head_s[2];
    bus.OD       = head_s[3];
    bus.OA_VALID = valid_s[0];
    bus.OB_VALID = valid_s[1];
    bus.OC_VALID = valid_s[2];
    bus.OD_VALID = valid_s[3];
    bus.FULL     = full_s;
  end

  // Storage array; stale entries are never visible because the head is gated.
  always_ff @(posedge CLK) begin
    for (int c = 0; c < 4; c++) begin
      if (push_s[c] && !RST) begin
        mem_r[c][wr_ptr_r[c]] <= bus.I;
      end
    end
  end

  // Pointers and counts; reset discards every buffered word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int c = 0; c < 4; c++) begin
        wr_ptr_r[c] <= '0;
        rd_ptr_r[c] <= '0;
        count_r[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (push_s[c]) begin
          wr_ptr_r[c] <= wr_ptr_r[c] + PTR_ONE;
        end
        if (pop_s[c]) begin
          rd_ptr_r[c] <= rd_ptr_r[c] + PTR_ONE;
        end
        case ({push_s[c], pop_s[c]})
          2'b10:   count_r[c] <= count_r[c] + CNT_ONE;
          2'b01:   count_r[c] <= count_r[c] - CNT_ONE;
          default: count_r[c] <= count_r[c];
        endcase
      end
    end
  end
endmodule

// File: tb/tb_demux14_buffered.sv
// Bench for demux14_buffered: directed vector table, corner-case sequences and
// random traffic, all checked against a per-channel queue model.
module tb_demux14_buffered;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  demux14_buffered_if #(.WIDTH(WIDTH)) bus ();

  demux14_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef logic [WIDTH-1:0] word_q_t [$];
  word_q_t mq [4];
  word_q_t seen_c;
  bit armed = 1'b0;
  int total = 0;
  int bad = 0;

  typedef struct {
    bit          rst;
    bit          iv;
    logic [1:0]  s;
    logic [31:0] din;
    logic [3:0]  rdy;
    bit          chk;
    bit          e_ir;
    logic [3:0]  e_v;
    logic [3:0]  e_f;
    int          e_ch;
    logic [31:0] e_d;
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] dut_data(input int c);
    case (c)
      0:       return bus.OA;
      1:       return bus.OB;
      2:       return bus.OC;
      default: return bus.OD;
    endcase
  endfunction

  task automatic drive(input bit rst, input bit iv, input logic [1:0] s,
                       input logic [31:0] din, input logic [3:0] rdy);
    RST          = rst;
    bus.I_VALID  = iv;
    bus.S        = s;
    bus.I        = din;
    bus.OA_READY = rdy[0];
    bus.OB_READY = rdy[1];
    bus.OC_READY = rdy[2];
    bus.OD_READY = rdy[3];
  endtask

  // Compare DUT against the queue model, then advance model and clock.
  task automatic step(input bit rst, input bit iv, input logic [1:0] s,
                      input logic [31:0] din, input logic [3:0] rdy);
    logic [3:0] ev, ef;
    bit accept;
    if (armed) begin
      for (int c = 0; c < 4; c++) begin
        ev[c] = (mq[c].size() != 0);
        ef[c] = (mq[c].size() == DEPTH);
        check($sformatf("data_ch%0d", c), 64'(dut_data(c)),
              64'(ev[c] ? mq[c][0] : 32'h0));
      end
      check("i_ready", 64'(bus.I_READY), 64'(mq[s].size() < DEPTH));
      check("valid", 64'({bus.OD_VALID, bus.OC_VALID, bus.OB_VALID, bus.OA_VALID}), 64'(ev));
      check("full", 64'(bus.FULL), 64'(ef));
    end
    if (!rst && bus.OC_VALID === 1'b1 && rdy[2]) seen_c.push_back(bus.OC);
    if (rst) begin
      for (int c = 0; c < 4; c++) mq[c].delete();
      armed = 1'b1;
    end else begin
      accept = iv && (mq[s].size() < DEPTH);
      for (int c = 0; c < 4; c++)
        if (mq[c].size() != 0 && rdy[c]) void'(mq[c].pop_front());
      if (accept) mq[s].push_back(din);
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic cycle(input bit rst, input bit iv, input logic [1:0] s,
                       input logic [31:0] din, input logic [3:0] rdy);
    drive(rst, iv, s, din, rdy);
    #1;
    step(rst, iv, s, din, rdy);
  endtask

  initial begin
    drive(1'b1, 1'b0, 2'd0, 32'h0, 4'b0000);
    // rst iv s din rdy chk e_ir e_v e_f e_ch e_d
    tbl[0]  = '{1'b1, 1'b1, 2'd2, 32'hDEAD, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 2, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 2'd2, 32'hDEAD, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 2, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 2'd2, 32'hDEAD, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 2, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 2'd0, 32'h7,    4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0000, 0, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, 2'd1, 32'h5,    4'b1111, 1'b1, 1'b1, 4'b0001, 4'b0000, 0, 32'h7};
    tbl[5]  = '{1'b0, 1'b1, 2'd2, 32'h6,    4'b1111, 1'b1, 1'b1, 4'b0010, 4'b0000, 1, 32'h5};
    tbl[6]  = '{1'b0, 1'b1, 2'd3, 32'h0,    4'b1111, 1'b1, 1'b1, 4'b0100, 4'b0000, 2, 32'h6};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 32'h0,    4'b1111, 1'b1, 1'b1, 4'b1000, 4'b0000, 3, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 32'h0,    4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0000, 0, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 2'd1, 32'h1,    4'b1101, 1'b1, 1'b1, 4'b0000, 4'b0000, 1, 32'h0};
    tbl[10] = '{1'b0, 1'b1, 2'd1, 32'h2,    4'b1101, 1'b1, 1'b1, 4'b0010, 4'b0000, 1, 32'h1};
    tbl[11] = '{1'b0, 1'b1, 2'd1, 32'h3,    4'b1101, 1'b1, 1'b0, 4'b0010, 4'b0010, 1, 32'h1};
    tbl[12] = '{1'b0, 1'b1, 2'd1, 32'h3,    4'b1111, 1'b1, 1'b0, 4'b0010, 4'b0010, 1, 32'h1};
    tbl[13] = '{1'b0, 1'b1, 2'd1, 32'h3,    4'b1111, 1'b1, 1'b1, 4'b0010, 4'b0000, 1, 32'h2};
    tbl[14] = '{1'b0, 1'b0, 2'd1, 32'h0,    4'b1111, 1'b1, 1'b1, 4'b0010, 4'b0000, 1, 32'h3};
    tbl[15] = '{1'b0, 1'b0, 2'd1, 32'h0,    4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0000, 1, 32'h0};

    @(negedge CLK);
    for (int k = 0; k < 16; k++) begin
      drive(tbl[k].rst, tbl[k].iv, tbl[k].s, tbl[k].din, tbl[k].rdy);
      #1;
      if (tbl[k].chk) begin
        check($sformatf("row%0d_i_ready", k), 64'(bus.I_READY), 64'(tbl[k].e_ir));
        check($sformatf("row%0d_valid", k),
              64'({bus.OD_VALID, bus.OC_VALID, bus.OB_VALID, bus.OA_VALID}), 64'(tbl[k].e_v));
        check($sformatf("row%0d_full", k), 64'(bus.FULL), 64'(tbl[k].e_f));
        check($sformatf("row%0d_data", k), 64'(dut_data(tbl[k].e_ch)), 64'(tbl[k].e_d));
      end
      step(tbl[k].rst, tbl[k].iv, tbl[k].s, tbl[k].din, tbl[k].rdy);
    end

    // Head-of-line isolation: B full and stalled, A and D keep flowing.
    cycle(1'b0, 1'b1, 2'd1, 32'h11, 4'b1101);
    cycle(1'b0, 1'b1, 2'd1, 32'h22, 4'b1101);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, (k % 2 == 0) ? 2'd0 : 2'd3, 32'hB000 + 32'(k), 4'b1101);
      #1;
      check("hol_accept", 64'(bus.I_READY), 64'(1));
      check("hol_b_full", 64'(bus.FULL[1]), 64'(1));
      step(1'b0, 1'b1, (k % 2 == 0) ? 2'd0 : 2'd3, 32'hB000 + 32'(k), 4'b1101);
    end
    cycle(1'b0, 1'b0, 2'd0, 32'h0, 4'b1111);
    cycle(1'b0, 1'b0, 2'd0, 32'h0, 4'b1111);
    cycle(1'b0, 1'b0, 2'd0, 32'h0, 4'b1111);

    // Simultaneous push/pop on C with the pointers wrapping repeatedly.
    seen_c.delete();
    cycle(1'b0, 1'b1, 2'd2, 32'hA0, 4'b1011);
    for (int k = 1; k < 10; k++) cycle(1'b0, 1'b1, 2'd2, 32'hA0 + 32'(k), 4'b1111);
    cycle(1'b0, 1'b0, 2'd2, 32'h0, 4'b1111);
    check("wrap_count", 64'(seen_c.size()), 64'(10));
    for (int k = 0; k < 10 && k < seen_c.size(); k++)
      check($sformatf("wrap_word%0d", k), 64'(seen_c[k]), 64'(32'hA0 + 32'(k)));

    // Reset mid-operation with A and D holding two words each.
    cycle(1'b0, 1'b1, 2'd0, 32'hC1, 4'b0000);
    cycle(1'b0, 1'b1, 2'd0, 32'hC2, 4'b0000);
    cycle(1'b0, 1'b1, 2'd3, 32'hD1, 4'b0000);
    cycle(1'b0, 1'b1, 2'd3, 32'hD2, 4'b0000);
    cycle(1'b1, 1'b0, 2'd0, 32'h0, 4'b0000);
    drive(1'b0, 1'b1, 2'd0, 32'h55, 4'b1111);
    #1;
    check("mrst_valid", 64'({bus.OD_VALID, bus.OC_VALID, bus.OB_VALID, bus.OA_VALID}), 64'(0));
    check("mrst_oa", 64'(bus.OA), 64'(0));
    check("mrst_od", 64'(bus.OD), 64'(0));
    step(1'b0, 1'b1, 2'd0, 32'h55, 4'b1111);
    drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b1111);
    #1;
    check("mrst_first", 64'(bus.OA), 64'(32'h55));
    step(1'b0, 1'b0, 2'd0, 32'h0, 4'b1111);
    drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b1111);
    #1;
    check("mrst_only", 64'(bus.OA_VALID), 64'(0));
    step(1'b0, 1'b0, 2'd0, 32'h0, 4'b1111);

    // Random traffic against the queue model.
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(63) == 0), 1'($urandom), 2'($urandom), $urandom, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/demux14_buffered.md
# demux14_buffered

Buffered 1-to-4 demultiplexer for the MIPS datapath: it routes one input word stream to one of four output channels, chosen per word by a 2-bit select. It is the return direction of the 4-to-1 operand/write-back multiplexers. Each output channel has its own small FIFO and a valid/ready handshake, so a stalled consumer does not block words headed to the other channels until that consumer's FIFO fills.

## Interface
- WIDTH, 32, data word width in bits
- DEPTH, 2, entries per output FIFO; a power of two, at least 2

- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset, synchronous, active-high
- I  in  WIDTH  input word
- S  in  2  destination select for I: 00→A, 01→B, 10→C, 11→D
- I_VALID  in  1  I and S hold a word to route
- I_READY  out  1  the channel selected by S can take the word
- OA, OB, OC, OD  out  WIDTH  head word of each channel FIFO
- OA_VALID … OD_VALID  out  1  the channel FIFO is non-empty
- OA_READY … OD_READY  in  1  the consumer takes the head word
- FULL  out  4  per-channel full flags; bit 0 = A … bit 3 = D

## Operation
- Each channel has a DEPTH-entry circular FIFO with a write pointer, a read pointer and a count register. The count is wide enough to hold 0..DEPTH.
- Push to channel S happens on a rising edge when I_VALID && I_READY. At most one channel is pushed per cycle.
- Pop on channel X happens on a rising edge when OX_VALID && OX_READY. Any subset of the four channels may pop in the same cycle.
- I_READY = (count[S] < DEPTH). It is combinational on S and the current count only. It does not consider a same-cycle pop, so a full channel refuses the word even while it is draining.
- OX_VALID = (count[X] != 0).
- OX = FIFO entry at the read pointer when OX_VALID = 1. OX is forced to 0 when OX_VALID = 0.
- FULL[x] = (count[x] == DEPTH).
- Push and pop on the same non-full, non-empty channel in the same cycle: count is unchanged and both pointers advance.
- Push into an empty channel: the word appears on OX with OX_VALID = 1 the next cycle. There is no fall-through within the same cycle.
- Pointers wrap modulo DEPTH. No word is lost, duplicated or reordered within a channel.
- Word order across different channels is not defined.
- If I_VALID = 0, S and I are ignored. I_READY still reflects the channel S names.
- A refused word (I_VALID = 1, I_READY = 0) is not stored. The producer must hold I and S stable until acceptance.
- If S changes while I_VALID is high and unaccepted, the new S is used. This is a protocol violation that the block tolerates, not an error.

## Timing
- Reset (RST = 1 at a rising edge): all counts and pointers go to 0. On the next cycle every OX_VALID = 0, every OX = 0, FULL = 4'b0000, and I_READY = 1 for every S.
- RST overrides any push or pop in the same cycle. Words held in the FIFOs at reset are discarded.
- Latency from input accept to output valid: 1 cycle.
- Sustained throughput: 1 word/cycle into any channel whose consumer holds OX_READY = 1. A channel with a stalled consumer accepts exactly DEPTH words and then holds I_READY low whenever S selects it.
- After a pop from a full channel, I_READY for that channel rises in the following cycle.
- All outputs except I_READY come straight from registers or from the FIFO read mux. I_READY adds one 4:1 compare path on S.

## Test plan
- Reset check: hold RST = 1 for 2 cycles with I_VALID = 1 and S = 2'b10, then release. Expect OA..OD = 0, all valids 0, FULL = 0, I_READY = 1, and no word stored during reset.
- Routing: push 32'h7 to S = 00, 32'h5 to S = 01, 32'h6 to S = 10 and 32'h0 to S = 11 on consecutive cycles, all OX_READY = 1. Expect each value on OA, OB, OC, OD respectively, exactly one cycle after its accept, each valid for one cycle.
- Fill and stall, DEPTH = 2: OB_READY = 0; push 32'h1, 32'h2, then 32'h3 to S = 01. Expect I_READY = 0 on the third word and FULL = 4'b0010. Raise OB_READY: expect OB = 1 then 2, and 32'h3 accepted one cycle after the first pop.
- Head-of-line isolation: channel B full and stalled. Expect words to S = 00 and S = 11 accepted every cycle and delivered on OA and OD unchanged.
- Simultaneous push/pop with wrap-around: keep channel C at count 1 while pushing and popping every cycle for 10 words 32'hA0..32'hA9. Expect OC to emit them in order, count to stay at 1, and the pointers to wrap at least 4 times.
- Reset mid-operation: with channels A and D each holding 2 words, assert RST for one cycle. Expect all valids 0 and outputs 0 on the next cycle; a word pushed after reset is the first and only word seen on its channel.
